// File: rtl/sample_sum_accumulator.sv
// Serial group accumulator: sums NSAMP unsigned DW-bit samples and presents the sum on a valid/ready port.
// Optional feature macro SUM_AVG_EN adds a registered out_avg (sum >> log2(NSAMP), truncated).
module sample_sum_accumulator #(
    parameter int DW    = 8,
    parameter int NSAMP = 8,
    localparam int SW   = DW + $clog2(NSAMP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic          busy
`ifdef SUM_AVG_EN
    ,
    output logic [DW-1:0] out_avg
`endif
);

    localparam int LG = $clog2(NSAMP);
    localparam int CW = LG + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSAMP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends on state only; out_valid is a flop, so neither side
    // sees a combinational path from the other's control signals.
    state_t        state_q, state_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] out_sum_q, out_sum_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] sum_next;
    logic          beat;

    assign in_ready = (state_q != S_DONE);
    assign beat     = in_valid && in_ready;
    assign sum_next = acc_q + SW'(in_data);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            // Abort wins over any beat or output handshake; out_sum keeps its last value.
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat) begin
                        acc_d   = SW'(in_data);
                        cnt_d   = CW'(1);
                        state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        acc_d = sum_next;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            out_sum_d   = sum_next;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);

`ifdef SUM_AVG_EN
    logic [DW-1:0] out_avg_q, out_avg_d;

    // Mean is captured on the same edge as out_sum; the shift truncates.
    always_comb begin
        out_avg_d = out_avg_q;
        if (!clear && state_q == S_ACCUM && beat && cnt_q == LAST_CNT) begin
            out_avg_d = sum_next[SW-1:LG];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_avg_q <= '0;
        end else begin
            out_avg_q <= out_avg_d;
        end
    end

    assign out_avg = out_avg_q;
`endif

endmodule

// File: tb/tb_sample_sum_accumulator.sv
// Directed self-checking bench for sample_sum_accumulator (DW=8, NSAMP=8).
// Inputs change 1 time unit after the rising edge; outputs are checked at that point too.
module tb_sample_sum_accumulator;

    localparam int DW = 8;
    localparam int NSAMP = 8;
    localparam int SW = 11;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic          busy;
    logic [DW-1:0] out_avg;

    int total = 0;
    int bad   = 0;

    sample_sum_accumulator #(.DW(DW), .NSAMP(NSAMP)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
`ifdef SUM_AVG_EN
        ,
        .out_avg   (out_avg)
`endif
    );

`ifndef SUM_AVG_EN
    assign out_avg = '0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat; waits (bounded) for in_ready, then leaves in_valid low.
    task automatic send_beat(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 20 && !in_ready; t++) step();
        check("beat_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Called right after the edge capturing the final beat, with out_ready=1.
    task automatic expect_done(input string tag, input int sum, input int avg);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(out_sum), 32'(sum));
        check({tag, "_inready_done"}, 32'(in_ready), 32'd0);
`ifdef SUM_AVG_EN
        check({tag, "_avg"}, 32'(out_avg), 32'(avg));
`else
        if (avg < 0) check({tag, "_avg_unused"}, 32'(out_avg), 32'd0);
`endif
        step();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_inready_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_inready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_avg", 32'(out_avg), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Group 1..8 back to back: sum 36, mean 4.
        for (int i = 1; i <= 7; i++) send_beat(8'(i));
        check("g1_busy", 32'(busy), 32'd1);
        check("g1_early_valid", 32'(out_valid), 32'd0);
        send_beat(8'd8);
        expect_done("g1", 36, 4);

        // All-ones samples: maximum sum.
        for (int i = 0; i < NSAMP; i++) send_beat(8'hFF);
        expect_done("gmax", 2040, 255);

        // Backpressure: result held for 5 cycles while upstream keeps offering.
        out_ready = 1'b0;
        for (int i = 0; i < NSAMP; i++) send_beat(8'd5);
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(out_sum), 32'd40);
            check("bp_inready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_hold_last", 32'(out_sum), 32'd40);
        step();
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_inready_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < NSAMP; i++) send_beat(8'd7);
        expect_done("bp_next", 56, 7);

        // Gapped input with junk on in_data while in_valid is low.
        for (int i = 0; i < NSAMP; i++) begin
            send_beat(8'd3);
            if (i < NSAMP - 1) begin
                for (int g = 0; g < (i % 5); g++) begin
                    in_data = 8'hAA;
                    step();
                end
                in_data = 8'h00;
            end
        end
        expect_done("gap", 24, 3);

        // Abort mid-group; the beat coinciding with clear is dropped.
        for (int i = 0; i < 3; i++) send_beat(8'd9);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd9;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_sum_kept", 32'(out_sum), 32'd24);
        for (int i = 0; i < NSAMP; i++) send_beat(8'd2);
        expect_done("clr_next", 16, 2);

        // Async reset mid-group: takes effect without a clock edge.
        for (int i = 0; i < 5; i++) send_beat(8'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_mid_busy", 32'(busy), 32'd0);
        check("arst_mid_inready", 32'(in_ready), 32'd1);
        check("arst_mid_sum", 32'(out_sum), 32'd0);
        reset = 1'b0;
        step();

        // Async reset while holding a result in DONE.
        out_ready = 1'b0;
        for (int i = 0; i < NSAMP; i++) send_beat(8'd1);
        check("arst_done_pre", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_done_valid", 32'(out_valid), 32'd0);
        check("arst_done_sum", 32'(out_sum), 32'd0);
        check("arst_done_busy", 32'(busy), 32'd0);
        check("arst_done_avg", 32'(out_avg), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        for (int i = 0; i < NSAMP; i++) send_beat(8'd1);
        expect_done("arst_next", 8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
